// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU constants and result record for the issue/collect controllers.
package fpu_pkg;
    localparam int FMUL_LAT  = 2;
    localparam int FPU_TAG_W = 5;
    typedef struct packed {
        logic [31:0]          data;
        logic [FPU_TAG_W-1:0] tag;
    } fpu_result_t;
endpackage

// File: rtl/fmul_issue_if.sv
// fmul_issue_if: request, result and multiplier-side signals of the fmul issue controller.
interface fmul_issue_if #(parameter int TAG_W = fpu_pkg::FPU_TAG_W);
    logic             in_valid, in_ready;
    logic [31:0]      in_s, in_t;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      fmul_s, fmul_t, fmul_d;
    logic             out_valid, out_ready;
    logic [31:0]      out_d;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    modport master (
        output in_valid, in_s, in_t, in_tag, out_ready, fmul_d,
        input  in_ready, fmul_s, fmul_t, out_valid, out_d, out_tag, busy
    );
    modport slave (
        input  in_valid, in_s, in_t, in_tag, out_ready, fmul_d,
        output in_ready, fmul_s, fmul_t, out_valid, out_d, out_tag, busy
    );
endinterface

// File: rtl/fpu_sync_fifo.sv
// fpu_sync_fifo: in-order ring-buffer FIFO with registered full/empty flags.
module fpu_sync_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic          r_full, r_empty;
    logic          w_wr, w_rd;
    logic [AW-1:0] w_wr_nx, w_rd_nx;

    assign w_wr    = i_push && !r_full;
    assign w_rd    = i_pop && !r_empty;
    assign w_wr_nx = (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
    assign w_rd_nx = (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
    assign o_empty = r_empty;
    assign o_data  = r_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr) r_wr <= w_wr_nx;
            if (w_rd) r_rd <= w_rd_nx;
            // flags only move when occupancy actually changes
            if (w_wr && !w_rd) begin
                r_empty <= 1'b0;
                r_full  <= (w_wr_nx == r_rd);
            end else if (w_rd && !w_wr) begin
                r_full  <= 1'b0;
                r_empty <= (w_rd_nx == r_wr);
            end
        end
    end
endmodule

// File: rtl/fmul_issue.sv
// fmul_issue: credit-based issue into the non-stalling fmul pipeline with in-order result collection.
module fmul_issue
    import fpu_pkg::*;
#(
    parameter int LAT   = FMUL_LAT,
    parameter int TAG_W = FPU_TAG_W,
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         rstn,
    fmul_issue_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [CW-1:0]             r_credits;
    logic [LAT:0]              r_vld;
    logic [LAT:0][TAG_W-1:0]   r_tag;
    logic [31:0]               r_s, r_t;
    logic                      w_acc, w_pop, w_empty;
    logic [31+TAG_W:0]         w_head;

    assign w_pop         = bus.out_valid && bus.out_ready;
    assign bus.in_ready  = (r_credits != '0) || w_pop;
    assign w_acc         = bus.in_valid && bus.in_ready;
    assign bus.fmul_s    = r_s;
    assign bus.fmul_t    = r_t;
    assign bus.out_valid = !w_empty;
    assign bus.out_d     = w_head[31+TAG_W:TAG_W];
    assign bus.out_tag   = w_head[TAG_W-1:0];
    assign bus.busy      = (|r_vld) || !w_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_credits <= CW'(DEPTH);
            r_vld     <= '0;
            r_tag     <= '0;
            r_s       <= '0;
            r_t       <= '0;
        end else begin
            if (w_acc) begin
                r_s <= bus.in_s;
                r_t <= bus.in_t;
            end
            r_vld     <= {r_vld[LAT-1:0], w_acc};
            r_tag     <= {r_tag[LAT-1:0], bus.in_tag};
            r_credits <= r_credits + CW'(w_pop) - CW'(w_acc);
        end
    end

    // the last tracking stage lines up with fmul_d of the same operation
    fpu_sync_fifo #(.W(32 + TAG_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (r_vld[LAT]),
        .i_data  ({bus.fmul_d, r_tag[LAT]}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty)
    );
endmodule

// File: doc/fmul_issue.md
# fmul_issue

Issue/collect controller that wraps the pipelined single-precision multiplier in the FPU. It accepts operand pairs with a destination tag over a valid/ready handshake and drives them into the fixed-latency `fmul` pipeline. That pipeline cannot stall, so the controller tracks in-flight operations and captures each result into a small in-order result FIFO, which the writeback stage drains over a second valid/ready handshake. Credit-based issue guarantees no result is ever dropped.

## Interface
Parameters:
- `LAT`, 2: number of register stages inside `fmul`, i.e. edges from operands at `fmul_s`/`fmul_t` to the matching `fmul_d`.
- `TAG_W`, 5: destination tag width.
- `DEPTH`, 4: result FIFO entries, equal to the credit pool size. Must be ≥ `LAT`+2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rstn`  in  1  reset; asynchronous assertion, active-low.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  request accepted when high together with `in_valid`.
- `in_s`, `in_t`  in  32  IEEE-754 single operands.
- `in_tag`  in  `TAG_W`  destination tag.
- `fmul_s`, `fmul_t`  out  32  registered operands to the multiplier.
- `fmul_d`  in  32  multiplier result.
- `out_valid`  out  1  result FIFO non-empty.
- `out_ready`  in  1  writeback accepts the head.
- `out_d`  out  32  head result.
- `out_tag`  out  `TAG_W`  head tag.
- `busy`  out  1  any operation in flight or queued.

## Operation
- **Accept:** a request is accepted when `in_valid && in_ready`. On that edge, `in_s`/`in_t` are registered onto `fmul_s`/`fmul_t`, and a valid bit plus `in_tag` enter the tracking shift register. When no request is accepted, `fmul_s`/`fmul_t` hold their previous values.
- **Tracking shift register:** `LAT`+1 stages of {valid, tag}. When the last stage is valid, `fmul_d` is pushed into the FIFO together with that tag.
- **Credits:** a credit counter covers 0..`DEPTH` and resets to `DEPTH`.
  - Accept decrements it.
  - Pop (`out_valid && out_ready`) increments it.
  - Accept and pop on the same edge leave it unchanged.
- **Ready:** `in_ready = (credits != 0) || (out_valid && out_ready)`. This is combinational, so a pop frees a credit in the same cycle.
- **Result FIFO:** in-order, no bypass. `out_d`/`out_tag` show the head entry.
  - Push and pop may occur on the same edge at any occupancy.
  - Push while full is impossible by construction; the bench asserts it never happens.
  - Pop while empty cannot occur because `out_valid` is low.
- **Busy:** `busy` = any tracking valid bit set, or FIFO non-empty.
- **Ordering:** results leave in exactly acceptance order. Tags pass through unmodified and are not interpreted.
- **No special-value handling:** NaN, inf and zero are handled by `fmul` only.

## Timing
- **Reset values:** `out_valid`=0, `busy`=0, `fmul_s`=`fmul_t`=0, `out_d`=0, `out_tag`=0, credits=`DEPTH`, so `in_ready`=1. Upstream must not assert `in_valid` while `rstn` is low.
- **Latency:** for a request accepted at edge E0, the result is captured at E(`LAT`+1) and `out_valid` is high in the following cycle. With `LAT`=2 that is 3 edges, and the earliest pop is at E4.
- **Throughput:** 1 op/cycle sustained while `out_ready`=1 and `DEPTH` ≥ `LAT`+2.
- **Backpressure:** with `out_ready`=0, exactly `DEPTH` requests are accepted, then `in_ready`=0 until a pop.
- **Reset mid-operation:** all in-flight and queued results are discarded and credits are restored to `DEPTH`. A multiplier output appearing after reset release is not captured.

## Structure
- **Shared package `fpu_pkg`:** `FMUL_LAT` (=2), `FPU_TAG_W` (=5), and the `fpu_result_t` typedef {data[31:0], tag}.
- **Sub-module `fpu_sync_fifo`:** parameterised width/depth, pointer wrap-around, separate full/empty flags. It is reused later for the fadd/fdiv controllers.
- **Top-level contents:** credit counter, tracking shift register, operand registers and ready logic.

## Test plan
- **Reset:** hold `rstn`=0 for 3 cycles, then release → `out_valid`=0, `busy`=0, `in_ready`=1; `fmul_s`=0.
- **Single op:** `in_s`=0x40000000, `in_t`=0x40400000, tag 3, with a behavioural `fmul` model (`LAT`=2) → `out_valid` rises in the cycle after the third edge, `out_d`=0x40C00000, `out_tag`=3; `busy` falls after the pop.
- **Streaming:** 8 back-to-back requests, tags 0..7, `out_ready`=1 → `in_ready` never drops; outputs emerge with tags 0..7, one per cycle, with no gaps.
- **Backpressure:** `out_ready`=0 with `in_valid` held → exactly 4 accepts, then `in_ready`=0. Raising `out_ready` drains tags in order, and `in_ready` returns to 1 in the same cycle as the first pop.
- **Simultaneous events:** credits=0 and FIFO full, `out_ready`=1, `in_valid`=1 → accept and pop on the same edge; credits stay 0; no overflow assertion fires.
- **Reset mid-operation:** 2 ops in flight plus 2 queued, then pulse `rstn` low asynchronously mid-cycle → `out_valid` drops immediately; no `out_valid` for 10 cycles after release; then 4 new accepts succeed.
